// File: rtl/io_stage.sv
// Memory-response (IO) stage: merges load read data, owns HI/LO, and feeds WB
// plus the ID forwarding network. The pipeline bus packages live alongside.

package cpu_core_params;
  parameter int unsigned CPU_DATA_WIDTH = 32;
endpackage

package ex_stage_params;
  import cpu_core_params::*;

  typedef enum logic [2:0] {
    MemByte  = 3'd0,
    MemHalf  = 3'd1,
    MemWord  = 3'd2,
    MemLeft  = 3'd3,
    MemRight = 3'd4
  } MemIoType;

  typedef struct packed {
    logic [CPU_DATA_WIDTH-1:0]   program_count;
    logic [CPU_DATA_WIDTH-1:0]   alu_result;
    logic [4:0]                  destination_register;
    logic                        register_write;
    logic                        result_is_from_memory;
    MemIoType                    memory_io_type;
    logic                        memory_io_unsigned;
    logic [1:0]                  memory_address_final;
    logic                        result_high;
    logic                        result_low;
    logic                        high_low_write;
    logic                        multiply_valid;
    logic [2*CPU_DATA_WIDTH-1:0] multiply_result;
    logic                        divide_valid;
    logic                        divide_result_valid;
    logic [CPU_DATA_WIDTH-1:0]   divide_result;
    logic [CPU_DATA_WIDTH-1:0]   divide_remain;
  } EXToIOData;
endpackage

package io_stage_params;
  import cpu_core_params::*;

  typedef struct packed {
    logic                      valid;
    logic [CPU_DATA_WIDTH-1:0] program_count;
    logic [CPU_DATA_WIDTH-1:0] final_result;
    logic [4:0]                register_file_address;
    logic                      register_file_write_enabled;
    logic [3:0]                register_file_write_strobe;
  } IOToWBData;

  typedef struct packed {
    logic                      valid;
    logic [4:0]                write_register;
    logic [3:0]                write_strobe;
    logic [CPU_DATA_WIDTH-1:0] write_data;
    logic                      previous_valid;
    logic [4:0]                previous_write_register;
    logic [CPU_DATA_WIDTH-1:0] previous_write_data;
  } IOToIDBackPassData;
endpackage

module io_stage
  import cpu_core_params::*;
  import ex_stage_params::*;
  import io_stage_params::*;
(
  input  logic                      clock,
  input  logic                      reset_n,
  input  logic                      ex_to_io_valid,
  input  EXToIOData                 ex_to_io_bus,
  output logic                      io_allowin,
  input  logic [CPU_DATA_WIDTH-1:0] data_sram_rdata,
  input  logic                      wb_allowin,
  output logic                      io_to_wb_valid,
  output IOToWBData                 io_to_wb_bus,
  output IOToIDBackPassData         io_to_id_back_pass
);

  logic                      io_valid_q, io_valid_d;
  EXToIOData                 io_data_q, io_data_d;
  logic [CPU_DATA_WIDTH-1:0] hi_q, hi_d;
  logic [CPU_DATA_WIDTH-1:0] lo_q, lo_d;
  logic                      prev_valid_q, prev_valid_d;
  logic [4:0]                prev_reg_q, prev_reg_d;
  logic [CPU_DATA_WIDTH-1:0] prev_data_q, prev_data_d;

  logic                      io_ready_go;
  logic                      fire;
  logic [CPU_DATA_WIDTH-1:0] load_data;
  logic [3:0]                load_strobe;
  logic [CPU_DATA_WIDTH-1:0] final_result;
  logic [3:0]                write_strobe;
  logic [7:0]                byte_sel;
  logic [15:0]               half_sel;
  logic [1:0]                addr_n;

  // Read data arrives in the same cycle the load is held, so IO never waits.
  assign io_ready_go    = 1'b1;
  assign io_allowin     = !io_valid_q || (io_ready_go && wb_allowin);
  assign io_to_wb_valid = io_valid_q && io_ready_go;
  assign fire           = io_to_wb_valid && wb_allowin;

  always_comb begin
    io_valid_d = io_valid_q;
    io_data_d  = io_data_q;
    if (io_allowin) begin
      io_valid_d = ex_to_io_valid;
    end
    if (io_allowin && ex_to_io_valid) begin
      io_data_d = ex_to_io_bus;
    end
  end

  // Little-endian lane extraction for the load merge.
  assign addr_n   = io_data_q.memory_address_final;
  assign byte_sel = 8'(data_sram_rdata >> {addr_n, 3'b000});
  assign half_sel = addr_n[1] ? data_sram_rdata[31:16] : data_sram_rdata[15:0];

  always_comb begin
    load_data   = data_sram_rdata;
    load_strobe = 4'b1111;
    case (io_data_q.memory_io_type)
      MemByte: begin
        load_data = io_data_q.memory_io_unsigned ? {24'd0, byte_sel}
                                                 : {{24{byte_sel[7]}}, byte_sel};
      end
      MemHalf: begin
        load_data = io_data_q.memory_io_unsigned ? {16'd0, half_sel}
                                                 : {{16{half_sel[15]}}, half_sel};
      end
      MemLeft: begin
        load_data   = data_sram_rdata << {(2'd3 - addr_n), 3'b000};
        load_strobe = 4'b1111 << (2'd3 - addr_n);
      end
      MemRight: begin
        load_data   = data_sram_rdata >> {addr_n, 3'b000};
        load_strobe = 4'b1111 >> addr_n;
      end
      default: begin
        load_data   = data_sram_rdata;
        load_strobe = 4'b1111;
      end
    endcase
  end

  always_comb begin
    final_result = io_data_q.alu_result;
    write_strobe = 4'b1111;
    if (io_data_q.result_high && !io_data_q.high_low_write) begin
      final_result = hi_q;
    end else if (io_data_q.result_low && !io_data_q.high_low_write) begin
      final_result = lo_q;
    end else if (io_data_q.result_is_from_memory) begin
      final_result = load_data;
      write_strobe = load_strobe;
    end
  end

  // HI/LO commit only when the writer retires, so a stalled writer leaves them intact.
  always_comb begin
    hi_d = hi_q;
    lo_d = lo_q;
    if (fire) begin
      if (io_data_q.multiply_valid) begin
        hi_d = io_data_q.multiply_result[63:32];
        lo_d = io_data_q.multiply_result[31:0];
      end else if (io_data_q.divide_valid && io_data_q.divide_result_valid) begin
        lo_d = io_data_q.divide_result;
        hi_d = io_data_q.divide_remain;
      end else if (io_data_q.high_low_write && io_data_q.result_high) begin
        hi_d = io_data_q.alu_result;
      end else if (io_data_q.high_low_write && io_data_q.result_low) begin
        lo_d = io_data_q.alu_result;
      end
    end
  end

  always_comb begin
    prev_valid_d = 1'b0;
    prev_reg_d   = prev_reg_q;
    prev_data_d  = prev_data_q;
    if (fire) begin
      prev_valid_d = io_data_q.register_write;
      prev_reg_d   = io_data_q.destination_register;
      prev_data_d  = final_result;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      io_valid_q   <= 1'b0;
      io_data_q    <= '0;
      hi_q         <= '0;
      lo_q         <= '0;
      prev_valid_q <= 1'b0;
      prev_reg_q   <= '0;
      prev_data_q  <= '0;
    end else begin
      io_valid_q   <= io_valid_d;
      io_data_q    <= io_data_d;
      hi_q         <= hi_d;
      lo_q         <= lo_d;
      prev_valid_q <= prev_valid_d;
      prev_reg_q   <= prev_reg_d;
      prev_data_q  <= prev_data_d;
    end
  end

  always_comb begin
    io_to_wb_bus.valid                       = io_to_wb_valid;
    io_to_wb_bus.program_count               = io_data_q.program_count;
    io_to_wb_bus.final_result                = final_result;
    io_to_wb_bus.register_file_address       = io_data_q.destination_register;
    io_to_wb_bus.register_file_write_enabled = io_data_q.register_write;
    io_to_wb_bus.register_file_write_strobe  = write_strobe;
  end

  always_comb begin
    io_to_id_back_pass.valid                   = io_valid_q && io_data_q.register_write;
    io_to_id_back_pass.write_register          = io_data_q.destination_register;
    io_to_id_back_pass.write_strobe            = write_strobe;
    io_to_id_back_pass.write_data              = final_result;
    io_to_id_back_pass.previous_valid          = prev_valid_q;
    io_to_id_back_pass.previous_write_register = prev_reg_q;
    io_to_id_back_pass.previous_write_data     = prev_data_q;
  end

endmodule

// File: tb/tb_io_stage.sv
// Scoreboard bench for io_stage: stimulus queues expected retirements, a
// negedge monitor compares them against the WB bus as they fire.

module tb_io_stage;
  import ex_stage_params::*;
  import io_stage_params::*;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] res;
    logic [3:0]  strb;
    logic [4:0]  rd;
    logic        we;
  } exp_t;

  logic              clock = 1'b0;
  logic              reset_n;
  logic              ex_to_io_valid;
  EXToIOData         ex_to_io_bus;
  logic              io_allowin;
  logic [31:0]       data_sram_rdata;
  logic              wb_allowin;
  logic              io_to_wb_valid;
  IOToWBData         io_to_wb_bus;
  IOToIDBackPassData io_to_id_back_pass;

  int   errors = 0;
  int   checks = 0;
  exp_t exp_q[$];
  exp_t mon_e;

  always #5 clock = ~clock;

  io_stage dut (
    .clock              (clock),
    .reset_n            (reset_n),
    .ex_to_io_valid     (ex_to_io_valid),
    .ex_to_io_bus       (ex_to_io_bus),
    .io_allowin         (io_allowin),
    .data_sram_rdata    (data_sram_rdata),
    .wb_allowin         (wb_allowin),
    .io_to_wb_valid     (io_to_wb_valid),
    .io_to_wb_bus       (io_to_wb_bus),
    .io_to_id_back_pass (io_to_id_back_pass)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  always @(negedge clock) begin
    if (reset_n && io_to_wb_valid && wb_allowin) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_retire: got pc 0x%08h expected none",
                 io_to_wb_bus.program_count);
      end else begin
        mon_e = exp_q.pop_front();
        chk("wb_valid", 32'(io_to_wb_bus.valid), 32'd1);
        chk("wb_pc", io_to_wb_bus.program_count, mon_e.pc);
        chk("wb_result", io_to_wb_bus.final_result, mon_e.res);
        chk("wb_strobe", 32'(io_to_wb_bus.register_file_write_strobe), 32'(mon_e.strb));
        chk("wb_rd", 32'(io_to_wb_bus.register_file_address), 32'(mon_e.rd));
        chk("wb_we", 32'(io_to_wb_bus.register_file_write_enabled), 32'(mon_e.we));
      end
    end
  end

  function automatic EXToIOData mk(input logic [31:0] pc, input logic [31:0] alu,
                                   input logic [4:0] rd, input logic we);
    EXToIOData d;
    d                      = '0;
    d.program_count        = pc;
    d.alu_result           = alu;
    d.destination_register = rd;
    d.register_write       = we;
    return d;
  endfunction

  function automatic EXToIOData mk_load(input logic [31:0] pc, input MemIoType t,
                                        input logic uns, input logic [1:0] n);
    EXToIOData d;
    d                       = mk(pc, 32'h0, 5'd3, 1'b1);
    d.result_is_from_memory = 1'b1;
    d.memory_io_type        = t;
    d.memory_io_unsigned    = uns;
    d.memory_address_final  = n;
    return d;
  endfunction

  task automatic drive(input logic v, input EXToIOData d, input logic [31:0] rdata);
    ex_to_io_valid  = v;
    ex_to_io_bus    = d;
    data_sram_rdata = rdata;
    @(posedge clock);
    #1;
  endtask

  task automatic issue(input EXToIOData d, input logic [31:0] rdata,
                       input logic [31:0] res, input logic [3:0] strb);
    exp_t e;
    e.pc   = d.program_count;
    e.res  = res;
    e.strb = strb;
    e.rd   = d.destination_register;
    e.we   = d.register_write;
    exp_q.push_back(e);
    drive(1'b1, d, rdata);
  endtask

  task automatic idle(input int n);
    ex_to_io_valid = 1'b0;
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  // Load is held one cycle after acceptance, with its read word kept on rdata.
  task automatic load(input EXToIOData d, input logic [31:0] rdata,
                      input logic [31:0] res, input logic [3:0] strb);
    issue(d, rdata, res, strb);
    idle(1);
  endtask

  initial begin
    EXToIOData d;
    reset_n         = 1'b0;
    wb_allowin      = 1'b1;
    ex_to_io_valid  = 1'b0;
    ex_to_io_bus    = '0;
    data_sram_rdata = 32'h0;
    repeat (2) @(posedge clock);
    #1;
    reset_n = 1'b1;
    #1;
    chk("rst_allowin", 32'(io_allowin), 32'd1);
    chk("rst_wb_valid", 32'(io_to_wb_valid), 32'd0);
    chk("rst_bp_valid", 32'(io_to_id_back_pass.valid), 32'd0);
    chk("rst_prev_valid", 32'(io_to_id_back_pass.previous_valid), 32'd0);

    d = mk(32'h100, 32'hDEAD, 5'd2, 1'b1);
    d.result_high = 1'b1;
    issue(d, 32'h0, 32'h0, 4'hF);
    d = mk(32'h104, 32'hBEEF, 5'd2, 1'b1);
    d.result_low = 1'b1;
    issue(d, 32'h0, 32'h0, 4'hF);
    idle(2);

    load(mk_load(32'h200, MemByte, 1'b0, 2'd3), 32'h80FF_1234, 32'hFFFF_FF80, 4'hF);
    load(mk_load(32'h204, MemByte, 1'b1, 2'd3), 32'h80FF_1234, 32'h0000_0080, 4'hF);
    load(mk_load(32'h208, MemHalf, 1'b0, 2'd2), 32'h80FF_1234, 32'hFFFF_80FF, 4'hF);
    load(mk_load(32'h20C, MemHalf, 1'b1, 2'd0), 32'h80FF_9234, 32'h0000_9234, 4'hF);
    load(mk_load(32'h210, MemWord, 1'b0, 2'd0), 32'h80FF_1234, 32'h80FF_1234, 4'hF);
    load(mk_load(32'h214, MemLeft, 1'b0, 2'd1), 32'hAABB_CCDD, 32'hCCDD_0000, 4'hC);
    load(mk_load(32'h218, MemRight, 1'b0, 2'd2), 32'hAABB_CCDD, 32'h0000_AABB, 4'h3);
    load(mk_load(32'h21C, MemByte, 1'b0, 2'd1), 32'h80FF_1234, 32'h0000_0012, 4'hF);

    d = mk(32'h300, 32'h0, 5'd0, 1'b0);
    d.multiply_valid  = 1'b1;
    d.multiply_result = 64'h0000_0001_FFFF_FFFE;
    issue(d, 32'h0, 32'h0, 4'hF);
    d = mk(32'h304, 32'h0, 5'd6, 1'b1);
    d.result_high = 1'b1;
    issue(d, 32'h0, 32'h0000_0001, 4'hF);
    d = mk(32'h308, 32'h0, 5'd7, 1'b1);
    d.result_low = 1'b1;
    issue(d, 32'h0, 32'hFFFF_FFFE, 4'hF);
    idle(2);

    d = mk(32'h400, 32'h0, 5'd0, 1'b0);
    d.divide_valid        = 1'b1;
    d.divide_result_valid = 1'b1;
    d.divide_result       = 32'd7;
    d.divide_remain       = 32'd3;
    issue(d, 32'h0, 32'h0, 4'hF);
    // An MFHI waits in EX during the stall; it must pick up the remainder.
    wb_allowin = 1'b0;
    d = mk(32'h404, 32'h0, 5'd4, 1'b1);
    d.result_high = 1'b1;
    exp_q.push_back('{pc: 32'h404, res: 32'd3, strb: 4'hF, rd: 5'd4, we: 1'b1});
    ex_to_io_valid = 1'b1;
    ex_to_io_bus   = d;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("stall_allowin", 32'(io_allowin), 32'd0);
      chk("stall_wb_valid", 32'(io_to_wb_valid), 32'd1);
      chk("stall_pc", io_to_wb_bus.program_count, 32'h400);
      chk("stall_result", io_to_wb_bus.final_result, 32'h0);
      @(posedge clock);
      #1;
    end
    wb_allowin = 1'b1;
    @(posedge clock);
    #1;
    d = mk(32'h408, 32'h0, 5'd8, 1'b1);
    d.result_low = 1'b1;
    issue(d, 32'h0, 32'd7, 4'hF);
    idle(2);

    issue(mk(32'h500, 32'h10, 5'd5, 1'b1), 32'h0, 32'h10, 4'hF);
    ex_to_io_valid = 1'b0;
    #1;
    chk("bp_valid", 32'(io_to_id_back_pass.valid), 32'd1);
    chk("bp_reg", 32'(io_to_id_back_pass.write_register), 32'd5);
    chk("bp_data", io_to_id_back_pass.write_data, 32'h10);
    chk("bp_strobe", 32'(io_to_id_back_pass.write_strobe), 32'hF);
    @(posedge clock);
    #1;
    chk("prev_valid", 32'(io_to_id_back_pass.previous_valid), 32'd1);
    chk("prev_reg", 32'(io_to_id_back_pass.previous_write_register), 32'd5);
    chk("prev_data", io_to_id_back_pass.previous_write_data, 32'h10);
    chk("bp_valid_after", 32'(io_to_id_back_pass.valid), 32'd0);
    @(posedge clock);
    #1;
    chk("prev_valid_bubble", 32'(io_to_id_back_pass.previous_valid), 32'd0);

    // MTHI discarded by reset while held: HI must stay at zero.
    d = mk(32'h600, 32'h55, 5'd0, 1'b0);
    d.high_low_write = 1'b1;
    d.result_high    = 1'b1;
    drive(1'b1, d, 32'h0);
    reset_n        = 1'b0;
    ex_to_io_valid = 1'b0;
    @(posedge clock);
    #1;
    reset_n = 1'b1;
    #1;
    chk("midrst_wb_valid", 32'(io_to_wb_valid), 32'd0);
    d = mk(32'h604, 32'h0, 5'd9, 1'b1);
    d.result_high = 1'b1;
    issue(d, 32'h0, 32'h0, 4'hF);
    idle(2);

    d = mk(32'h700, 32'h1234_5678, 5'd0, 1'b0);
    d.high_low_write = 1'b1;
    d.result_low     = 1'b1;
    issue(d, 32'h0, 32'h1234_5678, 4'hF);
    d = mk(32'h704, 32'h0, 5'd10, 1'b1);
    d.result_low = 1'b1;
    issue(d, 32'h0, 32'h1234_5678, 4'hF);
    idle(2);

    for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(posedge clock);
    chk("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/io_stage.md
# io_stage

Memory-response (IO) stage of the five-stage MIPS pipeline. It is the consumer of the EX-to-IO bus `ex_stage_params::EXToIOData`. Each cycle it:
- latches one EX instruction under valid/allowin handshake;
- merges the returning data-SRAM read word into load results (LB/LBU/LH/LHU/LW/LWL/LWR);
- owns the architectural HI/LO registers, serving MULT/DIV/MTHI/MTLO/MFHI/MFLO;
- drives `io_stage_params::IOToWBData` to WB and `IOToIDBackPassData` to ID for forwarding.

## Interface
Parameters:
- none (widths come from `cpu_core_params::CPU_DATA_WIDTH` = 32)

Ports:
- `clock`  in  1  single clock, all state on rising edge
- `reset_n`  in  1  reset, synchronous, active-low
- `ex_to_io_valid`  in  1  EX presents an instruction
- `ex_to_io_bus`  in  EXToIOData  instruction payload
- `io_allowin`  out  1  IO can accept this cycle
- `data_sram_rdata`  in  32  read word for the load currently held in IO
- `wb_allowin`  in  1  WB can accept
- `io_to_wb_valid`  out  1  IO presents to WB
- `io_to_wb_bus`  out  IOToWBData  retiring payload
- `io_to_id_back_pass`  out  IOToIDBackPassData  forwarding info

## Operation
- **State**
  - `io_valid`: 1b
  - `io_data`: registered EXToIOData
  - `hi`, `lo`: 32b each
  - `prev_valid`/`prev_reg`/`prev_data`: previous retired write
- **Handshake**
  - `io_ready_go` = 1.
  - `io_allowin` = !io_valid | (io_ready_go & wb_allowin).
  - `io_to_wb_valid` = io_valid & io_ready_go.
  - `fire` = io_to_wb_valid & wb_allowin.
- **Latching**
  - When `io_allowin`: io_valid <= ex_to_io_valid.
  - When `io_allowin & ex_to_io_valid`: io_data <= ex_to_io_bus.
  - Otherwise hold.
- **Load merge** (n = memory_address_final, little-endian)
  - Byte loads: byte n of rdata; zero-extend if memory_io_unsigned, else sign-extend. Strobe 1111.
  - Half-word loads: halfword n[1]. Extension as for byte loads. Strobe 1111.
  - LW: rdata, strobe 1111.
  - LWL: data = rdata << 8*(3-n). Strobe n=0:1000, 1:1100, 2:1110, 3:1111.
  - LWR: data = rdata >> 8*n. Strobe n=0:1111, 1:0111, 2:0011, 3:0001.
- **final_result priority**
  1. result_high & !high_low_write → hi (MFHI)
  2. result_low & !high_low_write → lo (MFLO)
  3. result_is_from_memory → merged load data
  4. otherwise → alu_result
- **Non-load strobe**: 1111.
- **HI/LO update** (only on `fire`)
  - multiply_valid: hi <= multiply_result[63:32], lo <= multiply_result[31:0].
  - divide_valid & divide_result_valid: lo <= divide_result, hi <= divide_remain.
  - high_low_write & result_high: hi <= alu_result.
  - high_low_write & result_low: lo <= alu_result.
  - Flags are mutually exclusive per instruction.
  - No update without fire.
- **WB bus** (IOToWBData)
  - valid = io_to_wb_valid
  - program_count from io_data
  - final_result as above
  - register_file_address = destination_register
  - register_file_write_enabled = register_write
  - register_file_write_strobe as above
- **Back-pass (current)**
  - valid = io_valid & register_write
  - write_register = destination_register
  - write_strobe, write_data = final_result
- **Back-pass (previous)**
  - On fire: prev_valid <= register_write, prev_reg <= destination_register, prev_data <= final_result.
  - On any non-fire cycle: prev_valid <= 0.

## Timing
- **Reset** (`reset_n`=0 at edge):
  - io_valid, io_data, hi, lo, prev_* <= 0.
  - Outputs after reset: io_to_wb_valid=0, all back-pass valids=0, io_allowin=1.
  - Reset mid-operation discards the held instruction with no HI/LO update that cycle.
- **Latency**: one cycle EX→WB when wb_allowin=1. Loaded instruction is visible to WB the cycle after it is accepted.
- **Read data**: `data_sram_rdata` must be valid every cycle io_valid holds a load. Output is combinational from it.
- **Stall**
  - wb_allowin=0 with io_valid=1: hold io_data, io_allowin=0, outputs stable.
  - HI/LO are not written until fire.
- **Simultaneous retire and accept**: fire and accept in the same cycle are allowed. A back-to-back MTHI→MFHI reads the updated hi, because the write lands at the writer's fire edge.
- **Bubble**: ex_to_io_valid=0 with io_allowin=1 clears io_valid; io_data is don't-care.

## Test plan
- Reset then idle → io_allowin=1, io_to_wb_valid=0, back-pass valids 0, MFHI returns 0.
- LB, n=3, rdata=0x80FF_1234, signed → final_result 0xFFFF_FF80, strobe 1111; same with LBU → 0x0000_0080.
- LWL n=1, rdata=0xAABB_CCDD → data 0xCCDD_0000, strobe 1100. LWR n=2 → 0x0000_AABB, strobe 0011.
- MULT product 0x0000_0001_FFFF_FFFE, then MFHI next cycle → 0x0000_0001; MFLO → 0xFFFF_FFFE.
- DIV quotient 7, remainder 3 with wb_allowin=0 for 3 cycles → io_allowin=0, bus stable, hi/lo unchanged. Release → hi=3, lo=7 after fire.
- ADDU to r5 value 0x10 retires → next cycle previous_valid=1, previous_write_register=5, previous_write_data=0x10. A following bubble cycle → previous_valid=0.
